// File: rtl/panda_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// panda_dmem_arbiter_if
// Bundles the two requester ports (core LSU on port 0, DMA/debug on port 1)
// and the single data-memory port that the arbiter multiplexes them onto.
//
// Signals:
//   p0_*/p1_*   : per-port request (req, addr, wdata, we) and response
//                 (gnt, rvalid) handshake
//   rdata_o     : read data shared by both ports, qualified by pN_rvalid_o
//   mem_*       : request/response handshake towards the data memory
//
// Modports:
//   slave  : the arbiter side (consumes port requests, drives memory)
//   master : the environment side (requesters plus the memory itself)
// ---------------------------------------------------------------------------
interface panda_dmem_arbiter_if;

    logic        p0_req_i;
    logic [31:0] p0_addr_i;
    logic [31:0] p0_wdata_i;
    logic [3:0]  p0_we_i;
    logic        p1_req_i;
    logic [31:0] p1_addr_i;
    logic [31:0] p1_wdata_i;
    logic [3:0]  p1_we_i;

    logic        p0_gnt_o;
    logic        p1_gnt_o;
    logic        p0_rvalid_o;
    logic        p1_rvalid_o;
    logic [31:0] rdata_o;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_we_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  p0_req_i, p0_addr_i, p0_wdata_i, p0_we_i,
        input  p1_req_i, p1_addr_i, p1_wdata_i, p1_we_i,
        output p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, rdata_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output p0_req_i, p0_addr_i, p0_wdata_i, p0_we_i,
        output p1_req_i, p1_addr_i, p1_wdata_i, p1_we_i,
        input  p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, rdata_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/panda_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// panda_dmem_arbiter
// Two-port arbiter in front of the data memory. Port 0 is the core LSU,
// port 1 is the DMA/debug master. Only one memory transaction is ever in
// flight: a request is granted (possibly after waiting for mem_gnt_i), then
// the arbiter waits for mem_rvalid_i before accepting the next request.
//
// Parameters:
//   RR_EN : 1 = round-robin between the ports when both request,
//           0 = fixed priority, port 0 always wins
//
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : requester and memory handshake bundle (slave modport)
//   busy_o : high while a transaction is outstanding
// ---------------------------------------------------------------------------
module panda_dmem_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    panda_dmem_arbiter_if.slave         bus,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_e;

    state_e state_q, state_d;

    // owner: port currently holding the memory; last: port served most recently
    logic owner_q, owner_d;
    logic last_q, last_d;

    logic any_req;
    logic winner;
    logic sel;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        p0_gnt;
    logic        p1_gnt;
    logic        p0_rvalid;
    logic        p1_rvalid;
    logic [31:0] rdata;

    assign any_req = bus.p0_req_i | bus.p1_req_i;

    // Pick the winner among the current requesters. With both requesting,
    // round-robin hands the memory to the port that was not served last, so
    // each port waits at most one foreign transaction.
    always_comb begin
        winner = 1'b0;
        if (bus.p0_req_i && bus.p1_req_i) begin
            if (RR_EN) begin
                winner = ~last_q;
            end else begin
                winner = 1'b0;
            end
        end else if (bus.p1_req_i) begin
            winner = 1'b1;
        end
    end

    // Next-state and output logic. In IDLE the winner is presented to memory
    // in the same cycle it is chosen; once we move on, the locked owner_q
    // decides whose signals are driven and who sees gnt/rvalid. While reset
    // is held every output is forced low so nothing leaks out mid-reset.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        sel       = owner_q;
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_we    = 4'h0;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        rdata     = 32'h0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel     = winner;
                    mem_req = 1'b1;
                    owner_d = winner;
                    if (bus.mem_gnt_i) begin
                        state_d = WAIT_RVALID;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                sel     = owner_q;
                mem_req = 1'b1;
                if (bus.mem_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (bus.mem_rvalid_i) begin
                    p0_rvalid = ~owner_q;
                    p1_rvalid = owner_q;
                    rdata     = bus.mem_rdata_i;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_req) begin
            if (sel) begin
                mem_addr  = bus.p1_addr_i;
                mem_wdata = bus.p1_wdata_i;
                mem_we    = bus.p1_we_i;
            end else begin
                mem_addr  = bus.p0_addr_i;
                mem_wdata = bus.p0_wdata_i;
                mem_we    = bus.p0_we_i;
            end
            p0_gnt = bus.mem_gnt_i & ~sel;
            p1_gnt = bus.mem_gnt_i & sel;
        end

        if (rst_i) begin
            mem_req   = 1'b0;
            mem_addr  = 32'h0;
            mem_wdata = 32'h0;
            mem_we    = 4'h0;
            p0_gnt    = 1'b0;
            p1_gnt    = 1'b0;
            p0_rvalid = 1'b0;
            p1_rvalid = 1'b0;
            rdata     = 32'h0;
        end
    end

    // State, owner and last-served registers. Reset favours the core first
    // by pretending port 1 was served most recently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_we_o    = mem_we;
    assign bus.p0_gnt_o    = p0_gnt;
    assign bus.p1_gnt_o    = p1_gnt;
    assign bus.p0_rvalid_o = p0_rvalid;
    assign bus.p1_rvalid_o = p1_rvalid;
    assign bus.rdata_o     = rdata;

    assign busy_o = (state_q != IDLE) & ~rst_i;

endmodule

// File: tb/tb_panda_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_panda_dmem_arbiter
// Drives the same directed stimulus into a round-robin instance (rr) and a
// fixed-priority instance (fp). Expected grant/response events are queued
// per instance; a negedge monitor pops and compares whenever a DUT shows a
// gnt or rvalid.
// ---------------------------------------------------------------------------
module tb_panda_dmem_arbiter;

    typedef struct {
        bit          kind;
        bit          port;
        logic [31:0] data;
        logic [3:0]  we;
        bit          care;
    } exp_t;

    logic clk_i;
    logic rst_i;
    logic busy_rr;
    logic busy_fp;
    bit   mon_en;

    int compared;
    int mismatched;

    exp_t q_rr[$];
    exp_t q_fp[$];

    panda_dmem_arbiter_if bus_rr ();
    panda_dmem_arbiter_if bus_fp ();

    panda_dmem_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus_rr.slave),
        .busy_o (busy_rr)
    );

    panda_dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus_fp.slave),
        .busy_o (busy_fp)
    );

    // Both instances see identical requester and memory inputs
    assign bus_fp.p0_req_i     = bus_rr.p0_req_i;
    assign bus_fp.p0_addr_i    = bus_rr.p0_addr_i;
    assign bus_fp.p0_wdata_i   = bus_rr.p0_wdata_i;
    assign bus_fp.p0_we_i      = bus_rr.p0_we_i;
    assign bus_fp.p1_req_i     = bus_rr.p1_req_i;
    assign bus_fp.p1_addr_i    = bus_rr.p1_addr_i;
    assign bus_fp.p1_wdata_i   = bus_rr.p1_wdata_i;
    assign bus_fp.p1_we_i      = bus_rr.p1_we_i;
    assign bus_fp.mem_gnt_i    = bus_rr.mem_gnt_i;
    assign bus_fp.mem_rvalid_i = bus_rr.mem_rvalid_i;
    assign bus_fp.mem_rdata_i  = bus_rr.mem_rdata_i;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [37:0] act, input logic [37:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int inst, input bit kind, input bit port,
                        input logic [31:0] data, input logic [3:0] we, input bit care);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.data = data;
        e.we   = we;
        e.care = care;
        if (inst == 0) q_rr.push_back(e);
        else           q_fp.push_back(e);
    endtask

    task automatic pushBoth(input bit kind, input bit port, input logic [31:0] data,
                            input logic [3:0] we, input bit care);
        push(0, kind, port, data, we, care);
        push(1, kind, port, data, we, care);
    endtask

    // Set all environment inputs, then wait to the sampling point of this cycle
    task automatic applyStimulus(input logic p0r, input logic [31:0] p0a,
                                 input logic p1r, input logic [31:0] p1a,
                                 input logic [3:0] p1we, input logic [31:0] p1wd,
                                 input logic mg, input logic mr, input logic [31:0] mrd);
        bus_rr.p0_req_i     = p0r;
        bus_rr.p0_addr_i    = p0a;
        bus_rr.p0_wdata_i   = 32'h0C0C0C0C;
        bus_rr.p0_we_i      = 4'h0;
        bus_rr.p1_req_i     = p1r;
        bus_rr.p1_addr_i    = p1a;
        bus_rr.p1_wdata_i   = p1wd;
        bus_rr.p1_we_i      = p1we;
        bus_rr.mem_gnt_i    = mg;
        bus_rr.mem_rvalid_i = mr;
        bus_rr.mem_rdata_i  = mrd;
        @(negedge clk_i);
    endtask

    task automatic stepClk();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClk();
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_busy_rr", {37'h0, busy_rr}, 38'h0);
        checkOutput("rst_memreq_rr", {37'h0, bus_rr.mem_req_o}, 38'h0);
        checkOutput("rst_busy_fp", {37'h0, busy_fp}, 38'h0);
        stepClk();
        rst_i = 1'b0;
    endtask

    // Compare one instance's outputs in the current cycle against its queue
    task automatic scoreEvent(input int inst, input logic g0, input logic g1,
                              input logic r0, input logic r1, input logic [31:0] addr,
                              input logic [3:0] we, input logic [31:0] rd);
        exp_t  e;
        string nm;
        bit    empty;
        nm = (inst == 0) ? "rr" : "fp";
        empty = (inst == 0) ? (q_rr.size() == 0) : (q_fp.size() == 0);
        checkOutput({nm, "_onehot"}, {36'h0, g0 & g1, r0 & r1}, 38'h0);
        if (g0 || g1) begin
            if (empty) begin
                checkOutput({nm, "_unexpected_gnt"}, {36'h0, g1, g0}, 38'h0);
            end else begin
                e = (inst == 0) ? q_rr.pop_front() : q_fp.pop_front();
                checkOutput({nm, "_gnt"}, {1'b0, g1, addr, we}, {e.kind, e.port, e.data, e.we});
            end
        end
        if (r0 || r1) begin
            if (empty) begin
                checkOutput({nm, "_unexpected_rvalid"}, {36'h0, r1, r0}, 38'h0);
            end else begin
                e = (inst == 0) ? q_rr.pop_front() : q_fp.pop_front();
                checkOutput({nm, "_rvalid"}, {1'b1, r1, (e.care ? rd : 32'h0), 4'h0},
                            {e.kind, e.port, (e.care ? e.data : 32'h0), 4'h0});
            end
        end else begin
            checkOutput({nm, "_rdata_idle"}, {6'h0, rd}, 38'h0);
        end
    endtask

    // Monitor: every cycle, both instances are scored away from the clock edge
    always @(negedge clk_i) begin
        if (mon_en) begin
            scoreEvent(0, bus_rr.p0_gnt_o, bus_rr.p1_gnt_o, bus_rr.p0_rvalid_o,
                       bus_rr.p1_rvalid_o, bus_rr.mem_addr_o, bus_rr.mem_we_o, bus_rr.rdata_o);
            scoreEvent(1, bus_fp.p0_gnt_o, bus_fp.p1_gnt_o, bus_fp.p0_rvalid_o,
                       bus_fp.p1_rvalid_o, bus_fp.mem_addr_o, bus_fp.mem_we_o, bus_fp.rdata_o);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        rst_i      = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClk();
        mon_en = 1'b1;
        doReset();

        // Single core load: grant at cycle 0, data at cycle 1, idle at cycle 2
        pushBoth(0, 0, 32'h40, 4'h0, 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t1_memreq", {37'h0, bus_rr.mem_req_o}, 38'h1);
        checkOutput("t1_busy0", {37'h0, busy_rr}, 38'h0);
        stepClk();
        pushBoth(1, 0, 32'hDEADBEEF, 4'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("t1_busy1", {37'h0, busy_rr}, 38'h1);
        checkOutput("t1_memreq_rv", {37'h0, bus_rr.mem_req_o}, 38'h0);
        stepClk();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_busy2_rr", {37'h0, busy_rr}, 38'h0);
        checkOutput("t1_busy2_fp", {37'h0, busy_fp}, 38'h0);
        stepClk();

        // Simultaneous requests after reset: core first, then DMA, then core
        doReset();
        pushBoth(0, 0, 32'h10, 4'h0, 1);
        applyStimulus(1, 32'h10, 1, 32'h20, 0, 0, 1, 0, 0);
        stepClk();
        pushBoth(1, 0, 32'h11111111, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'h20, 0, 0, 0, 1, 32'h11111111);
        checkOutput("t2_addr_rv", {6'h0, bus_rr.mem_addr_o}, 38'h0);
        stepClk();
        pushBoth(0, 1, 32'h20, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'h20, 0, 0, 1, 0, 0);
        stepClk();
        pushBoth(1, 1, 32'h22222222, 4'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
        stepClk();
        pushBoth(0, 0, 32'h30, 4'h0, 1);
        applyStimulus(1, 32'h30, 1, 32'h34, 0, 0, 1, 0, 0);
        stepClk();
        pushBoth(1, 0, 32'h33333333, 4'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333);
        stepClk();
        idleCycle();

        // Both ports request continuously for three back-to-back transactions
        doReset();
        for (int i = 0; i < 3; i++) begin
            push(0, 0, (i == 1), (i == 1) ? 32'h60 : 32'h50, 4'h0, 1);
            push(1, 0, 1'b0, 32'h50, 4'h0, 1);
            applyStimulus(1, 32'h50, 1, 32'h60, 0, 0, 1, 0, 0);
            stepClk();
            push(0, 1, (i == 1), 32'h1000 + i, 4'h0, 1);
            push(1, 1, 1'b0, 32'h1000 + i, 4'h0, 1);
            applyStimulus(1, 32'h50, 1, 32'h60, 0, 0, 0, 1, 32'h1000 + i);
            stepClk();
        end
        idleCycle();

        // DMA locked while memory stalls; core request and a stray rvalid arrive meanwhile
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c >= 2), 32'h300, 1, 32'h200, 0, 0, 0, (c == 3), 32'hBADBAD00);
            checkOutput($sformatf("t4_addr_rr_c%0d", c), {6'h0, bus_rr.mem_addr_o}, {6'h0, 32'h200});
            checkOutput($sformatf("t4_addr_fp_c%0d", c), {6'h0, bus_fp.mem_addr_o}, {6'h0, 32'h200});
            stepClk();
        end
        pushBoth(0, 1, 32'h200, 4'h0, 1);
        applyStimulus(1, 32'h300, 1, 32'h200, 0, 0, 1, 0, 0);
        stepClk();
        pushBoth(1, 1, 32'h44444444, 4'h0, 1);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h44444444);
        stepClk();
        pushBoth(0, 0, 32'h300, 4'h0, 1);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, 0, 0);
        stepClk();
        pushBoth(1, 0, 32'h55555555, 4'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555);
        stepClk();
        idleCycle();

        // Reset while waiting for the response, then a stray rvalid
        pushBoth(0, 0, 32'h70, 4'h0, 1);
        applyStimulus(1, 32'h70, 0, 0, 0, 0, 1, 0, 0);
        stepClk();
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
        checkOutput("t5_rvalid_rr", {36'h0, bus_rr.p1_rvalid_o, bus_rr.p0_rvalid_o}, 38'h0);
        checkOutput("t5_busy_rr", {37'h0, busy_rr}, 38'h0);
        checkOutput("t5_busy_fp", {37'h0, busy_fp}, 38'h0);
        stepClk();
        idleCycle();

        // DMA store with partial byte enables
        pushBoth(0, 1, 32'h100, 4'b0011, 1);
        applyStimulus(0, 0, 1, 32'h100, 4'b0011, 32'hA5A5A5A5, 1, 0, 0);
        checkOutput("t6_wdata", {6'h0, bus_rr.mem_wdata_o}, {6'h0, 32'hA5A5A5A5});
        stepClk();
        pushBoth(1, 1, 32'h0, 4'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
        stepClk();
        idleCycle();

        mon_en = 1'b0;
        checkOutput("rr_queue_drained", 38'(q_rr.size()), 38'h0);
        checkOutput("fp_queue_drained", 38'(q_fp.size()), 38'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/panda_dmem_arbiter.md
PANDA_DMEM_ARBITER -- requirements
Module: panda_dmem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin between ports, 0 = fixed priority with port 0 (core) always winning.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 p0_req_i, p1_req_i  input  1 each  request valid; port 0 = core LSU, port 1 = DMA/debug.
REQ-005 p0_addr_i, p1_addr_i  input  32 each  byte address.
REQ-006 p0_wdata_i, p1_wdata_i  input  32 each  store data.
REQ-007 p0_we_i, p1_we_i  input  4 each  byte write enables; 0 = load.
REQ-008 p0_gnt_o, p1_gnt_o  output  1 each  request accepted by memory.
REQ-009 p0_rvalid_o, p1_rvalid_o  output  1 each  response valid for that port.
REQ-010 rdata_o  output  32  shared read data, valid only with a pN_rvalid_o.
REQ-011 mem_req_o  output  1  request to data memory.
REQ-012 mem_addr_o, mem_wdata_o  output  32 each; mem_we_o  output  4.
REQ-013 mem_gnt_i, mem_rvalid_i  input  1 each; mem_rdata_i  input  32.
REQ-014 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_GNT and WAIT_RVALID; at most one transaction outstanding.
REQ-016 Requesters SHALL hold req, addr, wdata and we stable from req rise until their gnt; the arbiter does not check this.
REQ-017 In IDLE with any request, the arbiter SHALL select a winner combinationally, assert mem_req_o and drive the winner's addr/wdata/we in the same cycle.
REQ-018 Selection: only one requesting port wins; both requesting with RR_EN=1 -> the port not served last wins; RR_EN=0 -> port 0 wins.
REQ-019 Whenever mem_gnt_i=1 while mem_req_o=1, the winner's gnt_o SHALL be 1 in that cycle (combinational pass-through) and next state SHALL be WAIT_RVALID.
REQ-020 IDLE with request but mem_gnt_i=0 -> WAIT_GNT; the winner SHALL be locked in a register, with no re-arbitration until granted.
REQ-021 WAIT_GNT: mem_req_o=1 with locked owner's signals; the other port's request SHALL be ignored.
REQ-022 WAIT_RVALID: mem_req_o=0; mem_addr_o/mem_wdata_o/mem_we_o SHALL be 0; no gnt_o asserted.
REQ-023 On mem_rvalid_i in WAIT_RVALID: owner's rvalid_o=1 in the same cycle, rdata_o=mem_rdata_i, last-served pointer = owner, next state IDLE.
REQ-024 Stores also complete with mem_rvalid_i; rdata_o content is then don't-care.
REQ-025 Minimum transaction latency: request -> gnt 0 cycles, gnt -> rvalid at least 1 cycle; a new request SHALL NOT be issued in the rvalid cycle, so minimum occupancy is 2 cycles.
REQ-026 mem_rvalid_i in IDLE or WAIT_GNT SHALL be ignored: no rvalid_o and no state change.
REQ-027 Outside a response cycle, rdata_o SHALL be 0 and both rvalid_o SHALL be 0.
REQ-028 gnt_o and rvalid_o SHALL never be asserted to the non-owner port.
REQ-029 A non-winning request SHALL remain pending and SHALL be served next.
REQ-030 Worst-case wait with RR_EN=1 SHALL be one other transaction.

Reset
REQ-031 rst_i=1 at a clock edge SHALL force IDLE, owner=port 0, last-served=port 1 (core favoured first), regardless of current state.
REQ-032 During and after reset, all outputs SHALL be 0 until a new request arrives.
REQ-033 Reset mid-transaction SHALL abandon the outstanding access; a later mem_rvalid_i SHALL be ignored per REQ-026.

Verification
REQ-034 Single core load, mem_gnt_i=1 immediately, rvalid 1 cycle later with 0xDEADBEEF -> p0_gnt_o at cycle 0, p0_rvalid_o and rdata_o=0xDEADBEEF at cycle 1, busy_o low at cycle 2.
REQ-035 Both ports request at once after reset (RR_EN=1) -> port 0 granted first; port 1 granted on the first IDLE cycle after port 0's rvalid; a third simultaneous round goes to port 0.
REQ-036 RR_EN=0 with both requesting continuously for 3 transactions -> port 0 wins all three; p1_gnt_o never asserts.
REQ-037 mem_gnt_i held 0 for 5 cycles while port 1 is locked, and port 0 raises req at cycle 2 -> mem_addr_o stays p1_addr_i throughout, p1_gnt_o at cycle 5, port 0 served next.
REQ-038 rst_i pulsed in WAIT_RVALID, then stray mem_rvalid_i -> no rvalid_o, state IDLE, busy_o=0.
REQ-039 Store p1_we_i=4'b0011 to 0x100 -> mem_we_o=4'b0011 and mem_addr_o=0x100 in the grant cycle, p1_rvalid_o on completion, p0_rvalid_o stays 0.
